// File: rtl/sys_defs.sv
// Shared definitions for the dcache port arbiter: widths, the default
// starvation limit, the arbitration owner record and the dcache request.
package sys_defs;

  localparam int D_ADDR_W         = 32;
  localparam int DATA_W           = 32;
  localparam int LINE_W           = 64;
  localparam int BE_W             = 4;
  localparam int STARVE_LIMIT_DEF = 4;

  // Per-FU load response: data is a full cache line slice.
  typedef struct packed {
    logic              valid;
    logic [LINE_W-1:0] data;
  } cache_data_t;

  // Who owns the response arriving next cycle.
  typedef struct packed {
    logic       valid;
    logic       is_store;
    logic [1:0] fu_idx;
  } arb_owner_t;

  // Request presented to the dcache.
  typedef struct packed {
    logic                valid;
    logic                is_store;
    logic [D_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]   wdata;
    logic [BE_W-1:0]     be;
  } dcache_req_t;

endpackage

// File: rtl/dcache_port_arb_rr.sv
// rr_arbiter: combinational round-robin pick. Searches ptr, ptr+1, ...
// (mod N) and grants the first requester found, one-hot.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PTR_W'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcache_port_arb.sv
// dcache_port_arb: single dcache port shared by NUM_LD load FUs and the
// store-queue head. One grant per cycle, combinational. Stores normally win;
// loads rotate round-robin. The response comes back exactly one cycle after
// the grant and is routed to the owning load FU on a hit.
// Optional: DCACHE_ARB_STARVE_GUARD_EN enables a starvation counter that lets
// loads beat stores after STARVE_LIMIT consecutive store wins.
module dcache_port_arb
  import sys_defs::*;
#(
  parameter int NUM_LD       = 2,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_LD-1:0]                ld_req,
  input  logic [NUM_LD-1:0][D_ADDR_W-1:0]  ld_addr,
  output logic [NUM_LD-1:0]                ld_gnt,
  output cache_data_t [NUM_LD-1:0]         ld_resp,
  input  logic                             st_req,
  input  logic [D_ADDR_W-1:0]              st_addr,
  input  logic [DATA_W-1:0]                st_data,
  input  logic [BE_W-1:0]                  st_be,
  output logic                             st_gnt,
  output logic                             dc_req_valid,
  output logic                             dc_req_is_store,
  output logic [D_ADDR_W-1:0]              dc_req_addr,
  output logic [DATA_W-1:0]                dc_req_wdata,
  output logic [BE_W-1:0]                  dc_req_be,
  input  logic                             dc_busy,
  input  logic                             dc_resp_valid,
  input  logic                             dc_resp_hit,
  input  logic [LINE_W-1:0]                dc_resp_data
);

  localparam int PTR_W = (NUM_LD > 1) ? $clog2(NUM_LD) : 1;

  logic              any_ld, dc_free, ld_override, st_win, ld_win;
  logic [NUM_LD-1:0] rr_gnt;
  logic [PTR_W-1:0]  rr_ptr, gnt_idx;
  arb_owner_t        owner, owner_d;
  dcache_req_t       dc_req;
  logic              resp_ok;

  assign any_ld  = |ld_req;
  assign dc_free = !reset && !dc_busy;

`ifdef DCACHE_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign ld_override = any_ld && (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Count store wins that kept a waiting load out; any load win or an idle
  // load side clears it. Saturates at the limit.
  always_ff @(posedge clock) begin
    if (reset)
      starve_cnt <= '0;
    else if (!any_ld || ld_win)
      starve_cnt <= '0;
    else if (st_win && starve_cnt != CNT_W'(STARVE_LIMIT))
      starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign ld_override = 1'b0;
`endif

  assign st_win = dc_free && st_req && !ld_override;
  assign ld_win = dc_free && any_ld && !st_win;

  rr_arbiter #(.N(NUM_LD), .PTR_W(PTR_W)) u_rr (
    .req (ld_req),
    .ptr (rr_ptr),
    .gnt (rr_gnt)
  );

  assign ld_gnt = ld_win ? rr_gnt : '0;
  assign st_gnt = st_win;

  // Encode the one-hot load grant to an FU index.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_LD; i++)
      if (ld_gnt[i]) gnt_idx = PTR_W'(i);
  end

  // Mux the winner onto the dcache request; all-zero when nothing granted.
  always_comb begin
    dc_req = '0;
    if (st_win) begin
      dc_req.valid    = 1'b1;
      dc_req.is_store = 1'b1;
      dc_req.addr     = st_addr;
      dc_req.wdata    = st_data;
      dc_req.be       = st_be;
    end else if (ld_win) begin
      dc_req.valid    = 1'b1;
      dc_req.addr     = ld_addr[gnt_idx];
    end
  end

  assign dc_req_valid    = dc_req.valid;
  assign dc_req_is_store = dc_req.is_store;
  assign dc_req_addr     = dc_req.addr;
  assign dc_req_wdata    = dc_req.wdata;
  assign dc_req_be       = dc_req.be;

  // Round-robin pointer moves just past the FU that got a load grant.
  always_ff @(posedge clock) begin
    if (reset)
      rr_ptr <= '0;
    else if (ld_win)
      rr_ptr <= (gnt_idx == PTR_W'(NUM_LD - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Owner of next cycle's response; rewritten every cycle so an ungranted
  // cycle (including reset) leaves nothing in flight.
  always_comb begin
    owner_d          = '0;
    owner_d.valid    = dc_req.valid;
    owner_d.is_store = st_win;
    owner_d.fu_idx   = st_win ? 2'd0 : 2'(gnt_idx);
  end

  // Owner register, one-cycle response latency.
  always_ff @(posedge clock) begin
    if (reset) owner <= '0;
    else       owner <= owner_d;
  end

  assign resp_ok = !reset && dc_resp_valid && dc_resp_hit &&
                   owner.valid && !owner.is_store;

  // Route a load hit to its owning FU only.
  for (genvar g = 0; g < NUM_LD; g++) begin : g_resp
    assign ld_resp[g].valid = resp_ok && (owner.fu_idx == 2'(g));
    assign ld_resp[g].data  = (resp_ok && (owner.fu_idx == 2'(g))) ? dc_resp_data : '0;
  end

endmodule

// File: tb/tb_dcache_port_arb.sv
// Bench for dcache_port_arb (NUM_LD=2, STARVE_LIMIT=4). A behavioural model
// checks every cycle; directed scenarios pin the model with literal sequences.
module tb_dcache_port_arb;
  import sys_defs::*;

  localparam int NLD = 2;
  localparam int LIM = 4;
`ifdef DCACHE_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic                          clock = 1'b0;
  logic                          reset;
  logic [NLD-1:0]                ld_req;
  logic [NLD-1:0][D_ADDR_W-1:0]  ld_addr;
  logic [NLD-1:0]                ld_gnt;
  cache_data_t [NLD-1:0]         ld_resp;
  logic                          st_req;
  logic [D_ADDR_W-1:0]           st_addr;
  logic [DATA_W-1:0]             st_data;
  logic [BE_W-1:0]               st_be;
  logic                          st_gnt;
  logic                          dc_req_valid, dc_req_is_store;
  logic [D_ADDR_W-1:0]           dc_req_addr;
  logic [DATA_W-1:0]             dc_req_wdata;
  logic [BE_W-1:0]               dc_req_be;
  logic                          dc_busy, dc_resp_valid, dc_resp_hit;
  logic [LINE_W-1:0]             dc_resp_data;

  dcache_port_arb #(.NUM_LD(NLD), .STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt), .ld_resp(ld_resp),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
    .st_gnt(st_gnt),
    .dc_req_valid(dc_req_valid), .dc_req_is_store(dc_req_is_store),
    .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata), .dc_req_be(dc_req_be),
    .dc_busy(dc_busy), .dc_resp_valid(dc_resp_valid), .dc_resp_hit(dc_resp_hit),
    .dc_resp_data(dc_resp_data)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic prev_dcv = 1'b0;

  logic [1:0]  log_ld  [0:511];
  logic        log_st  [0:511];
  logic        log_dcv [0:511];
  logic [1:0]  log_rv  [0:511];
  logic [63:0] log_rd0 [0:511];
  logic [63:0] log_rd1 [0:511];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Model state: round-robin pointer, starvation count, in-flight owner.
  int   m_rr = 0, m_starve = 0, m_own_k = 0, k;
  bit   m_own_v = 0, m_own_st = 0;
  bit   any, ovr, e_st, e_ld_win;
  logic [1:0] e_ld;
  logic [D_ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0]   e_wdata;
  logic [BE_W-1:0]     e_be;
  cache_data_t [NLD-1:0] e_resp;

  // Compare process: derive this cycle's outputs from the rules, compare,
  // then advance the model as the clock edge will.
  always @(negedge clock) begin
    e_ld = '0; e_st = 0; e_ld_win = 0; e_addr = '0; e_wdata = '0; e_be = '0;
    e_resp = '0; k = 0;
    any = (ld_req != 0);
    if (!reset) begin
      ovr  = GUARD && any && (m_starve == LIM);
      e_st = !dc_busy && st_req && !ovr;
      e_ld_win = !dc_busy && any && !e_st;
      if (e_ld_win) begin
        for (int j = NLD - 1; j >= 0; j--)
          if (ld_req[(m_rr + j) % NLD]) k = (m_rr + j) % NLD;
        e_ld[k] = 1'b1;
        e_addr  = ld_addr[k];
      end
      if (e_st) begin
        e_addr = st_addr; e_wdata = st_data; e_be = st_be;
      end
      if (dc_resp_valid && dc_resp_hit && m_own_v && !m_own_st) begin
        e_resp[m_own_k].valid = 1'b1;
        e_resp[m_own_k].data  = dc_resp_data;
      end
    end
    chk("ld_gnt", 256'(ld_gnt), 256'(e_ld));
    chk("st_gnt", 256'(st_gnt), 256'(e_st));
    chk("dc_req_valid", 256'(dc_req_valid), 256'(e_st | e_ld_win));
    chk("dc_req_is_store", 256'(dc_req_is_store), 256'(e_st));
    chk("dc_req_addr", 256'(dc_req_addr), 256'(e_addr));
    chk("dc_req_wdata", 256'(dc_req_wdata), 256'(e_wdata));
    chk("dc_req_be", 256'(dc_req_be), 256'(e_be));
    chk("ld_resp", 256'(ld_resp), 256'(e_resp));
    log_ld[cyc]  = ld_gnt;
    log_st[cyc]  = st_gnt;
    log_dcv[cyc] = dc_req_valid;
    log_rv[cyc]  = {ld_resp[1].valid, ld_resp[0].valid};
    log_rd0[cyc] = ld_resp[0].data;
    log_rd1[cyc] = ld_resp[1].data;
    prev_dcv = dc_req_valid;
    if (reset) begin
      m_rr = 0; m_starve = 0; m_own_v = 0;
    end else begin
      if (e_ld_win) m_rr = (k + 1) % NLD;
      if (!any || e_ld_win) m_starve = 0;
      else if (e_st && m_starve < LIM) m_starve++;
      m_own_v  = e_st || e_ld_win;
      m_own_st = e_st;
      m_own_k  = k;
    end
    cyc++;
  end

  // One cycle: response for last cycle's grant (or forced), new requests.
  task automatic step(input logic [1:0] ld, input logic st, input logic busy,
                      input logic hit, input logic [63:0] rdata, input logic frc,
                      input logic rst, output int idx);
    @(posedge clock); #1;
    dc_resp_valid = prev_dcv | frc;
    dc_resp_hit   = hit;
    dc_resp_data  = rdata;
    reset  = rst;
    ld_req = ld;
    st_req = st;
    dc_busy = busy;
    ld_addr[0] = 32'h100 + 32'(cyc) * 4;
    ld_addr[1] = 32'h8000 + 32'(cyc) * 8;
    st_addr = 32'hA000 + 32'(cyc);
    st_data = 32'h5A5A0000 ^ 32'(cyc);
    st_be   = 4'(cyc) | 4'h1;
    idx = cyc;
  endtask

  localparam logic [63:0] HITD = 64'hDEADBEEF_01234567;

  int r0, c[0:4], p0, b0, q, s[0:5], a0, a1, a2, e0, e1, e2, t;

  initial begin
    reset = 1; ld_req = '0; ld_addr = '0; st_req = 0; st_addr = '0; st_data = '0;
    st_be = '0; dc_busy = 0; dc_resp_valid = 0; dc_resp_hit = 0; dc_resp_data = '0;

    // Reset with everything requesting: nothing may be granted.
    step(2'b11, 1, 0, 1, 64'h1, 1, 1, t);
    step(2'b11, 1, 0, 1, 64'h1, 1, 1, r0);

    // Two loads, always hit: alternating grants, responses one cycle later.
    for (int i = 0; i < 4; i++) step(2'b11, 0, 0, 1, 64'h1000 + 64'(i), 0, 0, c[i]);
    step(2'b00, 0, 0, 1, 64'h2000, 0, 0, c[4]);

    // Busy holds everything and keeps rr_ptr where it was (pointing at FU1).
    step(2'b01, 0, 0, 1, 64'h3000, 0, 0, p0);
    step(2'b11, 1, 1, 1, 64'h3001, 0, 0, b0);
    step(2'b11, 1, 1, 1, 64'h3002, 0, 0, t);
    step(2'b11, 0, 0, 1, 64'h3003, 0, 0, q);

    // Store vs a waiting load, 6 cycles.
    step(2'b00, 0, 0, 1, 64'h4000, 0, 0, t);
    for (int i = 0; i < 6; i++) step(2'b01, 1, 0, 1, 64'h4100 + 64'(i), 0, 0, s[i]);

    // Load miss then retry hit on FU1.
    step(2'b00, 0, 0, 1, 64'h5000, 0, 0, t);
    step(2'b10, 0, 0, 1, 64'h5001, 0, 0, a0);
    step(2'b10, 0, 0, 0, 64'h5002, 0, 0, a1);
    step(2'b00, 0, 0, 1, HITD,     0, 0, a2);

    // Reset right after a load grant; forced response after release.
    step(2'b01, 0, 0, 1, 64'h6000, 0, 0, e0);
    step(2'b01, 1, 0, 1, 64'h6001, 0, 1, e1);
    step(2'b00, 0, 0, 1, 64'h6002, 1, 0, e2);

    // Mixed traffic for the per-cycle model.
    step(2'b11, 1, 0, 1, 64'h7000, 0, 0, t);
    step(2'b10, 0, 1, 1, 64'h7001, 0, 0, t);
    step(2'b11, 0, 0, 1, 64'h7002, 0, 0, t);
    step(2'b11, 1, 0, 1, 64'h7003, 1, 0, t);
    step(2'b01, 0, 0, 0, 64'h7004, 0, 0, t);
    step(2'b00, 1, 0, 1, 64'h7005, 0, 0, t);
    step(2'b00, 0, 0, 1, 64'h7006, 0, 0, t);
    @(posedge clock); #1;

    chk("rst_ld_gnt", 256'(log_ld[r0]), 256'(2'b00));
    chk("rst_st_gnt", 256'(log_st[r0]), 256'(1'b0));
    chk("rst_dcv", 256'(log_dcv[r0]), 256'(1'b0));
    chk("rst_resp", 256'(log_rv[r0]), 256'(2'b00));
    for (int i = 0; i < 4; i++) begin
      chk("rr_gnt_seq", 256'(log_ld[c[i]]), 256'((i % 2 == 0) ? 2'b01 : 2'b10));
      chk("rr_resp_seq", 256'(log_rv[c[i] + 1]), 256'((i % 2 == 0) ? 2'b01 : 2'b10));
    end
    chk("pre_busy_gnt", 256'(log_ld[p0]), 256'(2'b01));
    chk("busy_ld_gnt", 256'(log_ld[b0]), 256'(2'b00));
    chk("busy_st_gnt", 256'(log_st[b0]), 256'(1'b0));
    chk("busy_dcv", 256'(log_dcv[b0]), 256'(1'b0));
    chk("post_busy_ptr", 256'(log_ld[q]), 256'(2'b10));
    for (int i = 0; i < 6; i++) begin
      if (GUARD) begin
        chk("starve_st", 256'(log_st[s[i]]), 256'(i != 4));
        chk("starve_ld", 256'(log_ld[s[i]]), 256'((i == 4) ? 2'b01 : 2'b00));
      end else begin
        chk("store_pri_st", 256'(log_st[s[i]]), 256'(1'b1));
        chk("store_pri_ld", 256'(log_ld[s[i]]), 256'(2'b00));
      end
      chk("store_resp_ignored", 256'(log_rv[s[i]]), 256'(2'b00));
    end
    chk("miss_first_gnt", 256'(log_ld[a0]), 256'(2'b10));
    chk("miss_no_resp", 256'(log_rv[a1]), 256'(2'b00));
    chk("miss_regrant", 256'(log_ld[a1]), 256'(2'b10));
    chk("hit_resp_valid", 256'(log_rv[a2]), 256'(2'b10));
    chk("hit_resp_data1", 256'(log_rd1[a2]), 256'(HITD));
    chk("hit_resp_data0", 256'(log_rd0[a2]), 256'(64'h0));
    chk("rst_mid_pre_gnt", 256'(log_ld[e0]), 256'(2'b01));
    chk("rst_mid_ld_gnt", 256'(log_ld[e1]), 256'(2'b00));
    chk("rst_mid_st_gnt", 256'(log_st[e1]), 256'(1'b0));
    chk("rst_mid_dcv", 256'(log_dcv[e1]), 256'(1'b0));
    chk("rst_mid_resp", 256'(log_rv[e1]), 256'(2'b00));
    chk("post_rst_resp", 256'(log_rv[e2]), 256'(2'b00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
